// File: rtl/tv_in_fetch.sv
// tv_in_fetch: fetches 32-bit words over an AXI4-Lite read master and
// serialises them little-endian into a first-word-fall-through byte FIFO.
module tv_in_fetch #(
    parameter int M_AXI_ADDR_WIDTH = 32,
    parameter int M_AXI_DATA_WIDTH = 32,
    parameter int REQ_DEPTH        = 4,
    parameter int BYTE_FIFO_DEPTH  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [M_AXI_ADDR_WIDTH-1:0] TV_REQ_ADDR,
    input  logic                        TV_REQ_WR_EN,
    output logic                        TV_REQ_READY,
    output logic [7:0]                  TV_IN_DATA,
    input  logic                        TV_IN_FIFO_RD_EN,
    output logic                        TV_IN_FIFO_NOT_EMPTY,
    output logic [M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                  m_axi_arprot,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    output logic                        o_rd_error,
    output logic                        o_req_overflow
);
    localparam int RA = $clog2(REQ_DEPTH);
    localparam int BA = $clog2(BYTE_FIFO_DEPTH);
    localparam logic [RA+1:0] REQ_LIM  = (RA+2)'(REQ_DEPTH);
    localparam logic [RA:0]   REQ_FULL = (RA+1)'(REQ_DEPTH);
    localparam logic [BA:0]   FIFO_LIM = (BA+1)'(BYTE_FIFO_DEPTH - 4);
    localparam logic [RA-1:0] R_ONE    = (RA)'(1);
    localparam logic [RA:0]   RC_ONE   = (RA+1)'(1);
    localparam logic [BA-1:0] B_ONE    = (BA)'(1);
    localparam logic [BA:0]   BC_ONE   = (BA+1)'(1);

    generate
        if (M_AXI_DATA_WIDTH != 32 || REQ_DEPTH < 2 || BYTE_FIFO_DEPTH < 8 ||
            (REQ_DEPTH & (REQ_DEPTH - 1)) != 0 ||
            (BYTE_FIFO_DEPTH & (BYTE_FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
            $error("tv_in_fetch: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_PUSH} state_t;

    state_t                      state_q, state_d;
    logic [M_AXI_ADDR_WIDTH-1:0] req_mem_q [REQ_DEPTH];
    logic [M_AXI_ADDR_WIDTH-1:0] req_mem_d [REQ_DEPTH];
    logic [RA-1:0]               req_wr_q, req_wr_d, req_rd_q, req_rd_d;
    logic [RA:0]                 req_cnt_q, req_cnt_d;
    logic [7:0]                  fifo_mem_q [BYTE_FIFO_DEPTH];
    logic [7:0]                  fifo_mem_d [BYTE_FIFO_DEPTH];
    logic [BA-1:0]               f_wr_q, f_wr_d, f_rd_q, f_rd_d;
    logic [BA:0]                 f_cnt_q, f_cnt_d;
    logic [M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                        arvalid_q, arvalid_d;
    logic                        rready_q, rready_d;
    logic [31:0]                 word_q, word_d;
    logic [1:0]                  byte_q, byte_d;
    logic                        rd_err_q, rd_err_d;
    logic                        ovf_q, ovf_d;
    logic                        req_push, req_pop, f_push, f_pop;
    logic [7:0]                  push_byte;
    logic [M_AXI_ADDR_WIDTH-1:0] req_aligned;
    logic                        unused_addr_bits;

    assign unused_addr_bits = ^TV_REQ_ADDR[1:0];
    assign req_aligned = {TV_REQ_ADDR[M_AXI_ADDR_WIDTH-1:2], 2'b00};

    // Pops are not credited here so a one-cycle-late requester never overruns.
    assign TV_REQ_READY = !i_rst &&
        (({1'b0, req_cnt_q} + {{(RA+1){1'b0}}, TV_REQ_WR_EN}) < REQ_LIM);

    assign TV_IN_FIFO_NOT_EMPTY = (f_cnt_q != '0);
    assign TV_IN_DATA    = TV_IN_FIFO_NOT_EMPTY ? fifo_mem_q[f_rd_q] : 8'h00;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign o_rd_error    = rd_err_q;
    assign o_req_overflow = ovf_q;

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        word_d    = word_q;
        byte_d    = byte_q;
        rd_err_d  = rd_err_q;
        ovf_d     = ovf_q;
        req_pop   = 1'b0;
        f_push    = 1'b0;
        push_byte = 8'h00;

        req_push = TV_REQ_WR_EN && (req_cnt_q != REQ_FULL);
        if (TV_REQ_WR_EN && (req_cnt_q == REQ_FULL)) ovf_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                // Reserve a whole word of FIFO space before issuing the read.
                if (req_cnt_q != '0 && f_cnt_q <= FIFO_LIM) begin
                    req_pop   = 1'b1;
                    araddr_d  = req_mem_q[req_rd_q];
                    arvalid_d = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (m_axi_rvalid && rready_q) begin
                    rready_d = 1'b0;
                    word_d   = m_axi_rdata[31:0];
                    byte_d   = 2'd0;
                    if (m_axi_rresp != 2'b00) rd_err_d = 1'b1;
                    state_d  = S_PUSH;
                end
            end
            S_PUSH: begin
                f_push    = 1'b1;
                push_byte = word_q[{byte_q, 3'b000} +: 8];
                byte_d    = byte_q + 2'd1;
                if (byte_q == 2'd3) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        req_mem_d = req_mem_q;
        req_wr_d  = req_wr_q;
        req_rd_d  = req_rd_q;
        req_cnt_d = req_cnt_q;
        if (req_push) begin
            req_mem_d[req_wr_q] = req_aligned;
            req_wr_d = req_wr_q + R_ONE;
        end
        if (req_pop) req_rd_d = req_rd_q + R_ONE;
        if (req_push && !req_pop) req_cnt_d = req_cnt_q + RC_ONE;
        if (!req_push && req_pop) req_cnt_d = req_cnt_q - RC_ONE;

        f_pop      = TV_IN_FIFO_RD_EN && TV_IN_FIFO_NOT_EMPTY;
        fifo_mem_d = fifo_mem_q;
        f_wr_d     = f_wr_q;
        f_rd_d     = f_rd_q;
        f_cnt_d    = f_cnt_q;
        if (f_push) begin
            fifo_mem_d[f_wr_q] = push_byte;
            f_wr_d = f_wr_q + B_ONE;
        end
        if (f_pop) f_rd_d = f_rd_q + B_ONE;
        if (f_push && !f_pop) f_cnt_d = f_cnt_q + BC_ONE;
        if (!f_push && f_pop) f_cnt_d = f_cnt_q - BC_ONE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            req_wr_q  <= '0;
            req_rd_q  <= '0;
            req_cnt_q <= '0;
            f_wr_q    <= '0;
            f_rd_q    <= '0;
            f_cnt_q   <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            word_q    <= '0;
            byte_q    <= 2'd0;
            rd_err_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_wr_q  <= req_wr_d;
            req_rd_q  <= req_rd_d;
            req_cnt_q <= req_cnt_d;
            f_wr_q    <= f_wr_d;
            f_rd_q    <= f_rd_d;
            f_cnt_q   <= f_cnt_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            word_q    <= word_d;
            byte_q    <= byte_d;
            rd_err_q  <= rd_err_d;
            ovf_q     <= ovf_d;
        end
        req_mem_q  <= req_mem_d;
        fifo_mem_q <= fifo_mem_d;
    end

endmodule

// File: tb/tb_tv_in_fetch.sv
// tb_tv_in_fetch: vector table plus hand sequences against an AXI4-Lite
// read slave model; expected bytes flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_tv_in_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_addr;
    logic        req_wr, req_ready;
    logic [7:0]  in_data;
    logic        rd_en, not_empty;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic        rd_error, req_ovf;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_ar_q[$];
    logic [31:0] sl_data_q[$];
    logic [1:0]  sl_resp_q[$];
    logic [7:0]  exp_b_q[$];

    int ar_dly = 0, r_dly = 0;
    int ar_wait = 0, r_wait = 0;
    int ar_run = 0, r_run = 0;
    int ar_hold = 0, r_hold = 0;
    int ar_cnt = 0;
    logic [31:0] ar_first = '0;
    bit ar_bad = 1'b0;

    always #5 clk = ~clk;

    tv_in_fetch dut (
        .i_clk(clk),
        .i_rst(rst),
        .TV_REQ_ADDR(req_addr),
        .TV_REQ_WR_EN(req_wr),
        .TV_REQ_READY(req_ready),
        .TV_IN_DATA(in_data),
        .TV_IN_FIFO_RD_EN(rd_en),
        .TV_IN_FIFO_NOT_EMPTY(not_empty),
        .m_axi_araddr(araddr),
        .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata(rdata),
        .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid),
        .m_axi_rready(rready),
        .o_rd_error(rd_error),
        .o_req_overflow(req_ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add_word(input logic [31:0] exar, input logic [31:0] d,
                            input logic [1:0] rs);
        exp_ar_q.push_back(exar);
        sl_data_q.push_back(d);
        sl_resp_q.push_back(rs);
        exp_b_q.push_back(d[7:0]);
        exp_b_q.push_back(d[15:8]);
        exp_b_q.push_back(d[23:16]);
        exp_b_q.push_back(d[31:24]);
    endtask

    task automatic strobe(input logic [31:0] a);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            cyc(1);
            n++;
        end
        if (!req_ready) fail_evt("strobe_ready");
        req_addr = a;
        req_wr = 1'b1;
        cyc(1);
        req_wr = 1'b0;
    endtask

    task automatic pop_byte();
        int n;
        logic [7:0] e;
        n = 0;
        while (!not_empty && n < 200) begin
            cyc(1);
            n++;
        end
        if (!not_empty) begin
            fail_evt("pop_wait");
            return;
        end
        if (exp_b_q.size() == 0) begin
            fail_evt("scoreboard_underrun");
            return;
        end
        e = exp_b_q.pop_front();
        chk("byte", {24'h0, in_data}, {24'h0, e});
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_sb();
        exp_ar_q.delete();
        sl_data_q.delete();
        sl_resp_q.delete();
        exp_b_q.delete();
    endtask

    // AXI4-Lite read slave: decisions made on the falling edge.
    initial begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        forever begin
            @(negedge clk);
            arready = 1'b0;
            rvalid  = 1'b0;
            if (rst) begin
                ar_wait = 0;
                r_wait  = 0;
                ar_run  = 0;
                r_run   = 0;
            end else begin
                if (!arvalid && ar_wait > 0) ar_bad = 1'b1;
                if (arvalid) begin
                    ar_run++;
                    if (ar_wait == 0) ar_first = araddr;
                    else if (araddr !== ar_first) ar_bad = 1'b1;
                    if (ar_wait < ar_dly) begin
                        ar_wait++;
                    end else begin
                        arready = 1'b1;
                        ar_hold = ar_run;
                        ar_run  = 0;
                        ar_wait = 0;
                        ar_cnt++;
                        if (exp_ar_q.size() == 0) fail_evt("ar_unexpected");
                        else chk("araddr", araddr, exp_ar_q.pop_front());
                    end
                end
                if (rready) begin
                    r_run++;
                    if (r_wait < r_dly) begin
                        r_wait++;
                    end else begin
                        rvalid = 1'b1;
                        r_hold = r_run;
                        r_run  = 0;
                        r_wait = 0;
                        if (sl_data_q.size() == 0) begin
                            fail_evt("slave_underrun");
                            rdata = 32'hDEAD_BEEF;
                            rresp = 2'b00;
                        end else begin
                            rdata = sl_data_q.pop_front();
                            rresp = sl_resp_q.pop_front();
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exar;
        logic [31:0] data;
        logic [1:0]  resp;
        int          ard;
        int          rd;
        logic        err;
    } vec_t;

    vec_t vt[4];

    initial begin
        int base;
        int n;

        vt[0] = '{32'hA000_0000, 32'hA000_0000, 32'h4433_2211, 2'b00, 0, 0, 1'b0};
        vt[1] = '{32'hA000_0003, 32'hA000_0000, 32'h8899_AABB, 2'b00, 1, 1, 1'b0};
        vt[2] = '{32'h1234_5678, 32'h1234_5678, 32'hCAFE_F00D, 2'b00, 5, 3, 1'b0};
        vt[3] = '{32'h0000_0041, 32'h0000_0040, 32'h0000_00FF, 2'b10, 0, 2, 1'b1};

        rst = 1'b1;
        req_addr = '0;
        req_wr = 1'b0;
        rd_en = 1'b0;
        cyc(3);
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_arvalid", {31'h0, arvalid}, 32'h0);
        chk("rst_rready", {31'h0, rready}, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_not_empty", {31'h0, not_empty}, 32'h0);
        chk("rst_data", {24'h0, in_data}, 32'h0);
        chk("rst_rd_error", {31'h0, rd_error}, 32'h0);
        chk("rst_overflow", {31'h0, req_ovf}, 32'h0);
        chk("arprot", {29'h0, arprot}, 32'h0);
        rst = 1'b0;
        cyc(1);
        chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

        // Latency: strobe in cycle t, NOT_EMPTY first seen in cycle t+5.
        add_word(32'h0000_0100, 32'h5566_7788, 2'b00);
        strobe(32'h0000_0100);
        cyc(3);
        chk("latency_t4", {31'h0, not_empty}, 32'h0);
        cyc(1);
        chk("latency_t5", {31'h0, not_empty}, 32'h1);
        repeat (3) pop_byte();

        // One byte left; popping while the next word streams in.
        add_word(32'h0000_0104, 32'h0D0C_0B0A, 2'b00);
        strobe(32'h0000_0104);
        repeat (5) pop_byte();
        chk("pushpop_drained", {31'h0, not_empty}, 32'h0);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        chk("pop_when_empty", {31'h0, not_empty}, 32'h0);

        for (int i = 0; i < 4; i++) begin
            ar_dly = vt[i].ard;
            r_dly  = vt[i].rd;
            ar_bad = 1'b0;
            add_word(vt[i].exar, vt[i].data, vt[i].resp);
            strobe(vt[i].addr);
            repeat (4) pop_byte();
            chk("ar_hold", 32'(ar_hold), 32'(vt[i].ard + 1));
            chk("r_hold", 32'(r_hold), 32'(vt[i].rd + 1));
            chk("ar_stable", {31'h0, ar_bad}, 32'h0);
            chk("rd_error", {31'h0, rd_error}, {31'h0, vt[i].err});
        end
        ar_dly = 0;
        r_dly  = 0;

        // Burst from a requester that registers READY into WR_EN.
        base = ar_cnt;
        add_word(32'hA000_0000, 32'h0302_0100, 2'b00);
        for (int k = 0; k < 8; k++)
            add_word(32'hB000_0000 + 32'(k * 4), 32'h1000_0000 * 32'(k + 1) + 32'h0055_AA11, 2'b00);
        strobe(32'hA000_0003);
        fork
            begin
                int left;
                int guard;
                logic rdy_s;
                left = 8;
                guard = 0;
                while (left > 0 && guard < 2000) begin
                    @(negedge clk);
                    rdy_s = req_ready;
                    @(posedge clk);
                    #1;
                    req_wr = rdy_s;
                    if (rdy_s) begin
                        req_addr = 32'hB000_0000 + 32'((8 - left) * 4);
                        left--;
                    end
                    guard++;
                end
                @(posedge clk);
                #1;
                req_wr = 1'b0;
                if (left > 0) fail_evt("burst_requester");
            end
            begin
                repeat (36) pop_byte();
            end
        join
        chk("burst_ar_count", 32'(ar_cnt - base), 32'd9);
        chk("burst_overflow", {31'h0, req_ovf}, 32'h0);
        chk("burst_drained", {31'h0, not_empty}, 32'h0);

        // Back-pressure: 4 words fill the FIFO, the 5th must wait.
        base = ar_cnt;
        for (int k = 0; k < 5; k++)
            add_word(32'hC000_0000 + 32'(k * 4), 32'hC0C0_0000 + 32'(k * 32'h0101), 2'b00);
        for (int k = 0; k < 5; k++)
            strobe(32'hC000_0000 + 32'(k * 4));
        cyc(60);
        chk("bp_ar_count", 32'(ar_cnt - base), 32'd4);
        chk("bp_arvalid", {31'h0, arvalid}, 32'h0);
        chk("bp_not_empty", {31'h0, not_empty}, 32'h1);

        // Forced strobes: queue holds 1, three fit, the fourth overflows.
        for (int k = 0; k < 3; k++)
            add_word(32'hD000_0000 + 32'(k * 4), 32'hD1D2_0000 + 32'(k), 2'b00);
        req_wr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr = 32'hD000_0000 + 32'(k * 4);
            if (k == 3) chk("ovf_before", {31'h0, req_ovf}, 32'h0);
            cyc(1);
        end
        req_wr = 1'b0;
        chk("ovf_set", {31'h0, req_ovf}, 32'h1);
        repeat (4) pop_byte();
        n = 0;
        while (ar_cnt - base < 5 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("bp_resume", 32'(ar_cnt - base), 32'd5);
        repeat (28) pop_byte();
        chk("bp_drained", {31'h0, not_empty}, 32'h0);
        chk("sb_empty", 32'(exp_b_q.size()), 32'h0);
        chk("ovf_sticky", {31'h0, req_ovf}, 32'h1);

        // Reset in the middle of PUSH, after two bytes.
        add_word(32'hE000_0000, 32'h7766_5544, 2'b00);
        strobe(32'hE000_0000);
        n = 0;
        while (!not_empty && n < 50) begin
            cyc(1);
            n++;
        end
        if (!not_empty) fail_evt("midpush_wait");
        cyc(1);
        rst = 1'b1;
        clear_sb();
        cyc(1);
        chk("mid_not_empty", {31'h0, not_empty}, 32'h0);
        chk("mid_arvalid", {31'h0, arvalid}, 32'h0);
        chk("mid_rready", {31'h0, rready}, 32'h0);
        chk("mid_rd_error", {31'h0, rd_error}, 32'h0);
        chk("mid_overflow", {31'h0, req_ovf}, 32'h0);
        chk("mid_data", {24'h0, in_data}, 32'h0);
        rst = 1'b0;
        cyc(1);

        add_word(32'hF000_0008, 32'hA1B2_C3D4, 2'b00);
        strobe(32'hF000_0008);
        repeat (4) pop_byte();
        chk("post_rst_drained", {31'h0, not_empty}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
